// File: rtl/idu_pipe_if.sv
// Handshake and data bundle between IFU, the decode stage, EXU and writeback.
// The stage uses the slave view; whatever drives it (fetch/exec/test) uses master.
interface idu_pipe_if #(
  parameter int XLEN    = 32,
  parameter int NR_REGS = 16
);
  localparam int AW = $clog2(NR_REGS);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_func3;
  logic            out_func7;
  logic [AW-1:0]   out_rs1;
  logic [AW-1:0]   out_rs2;
  logic [AW-1:0]   out_rd;
  logic [XLEN-1:0] out_imm;
  logic            out_rd_wen;
  logic            out_illegal;

  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic            flush;

  modport master (
    output in_valid, in_instr, in_pc, out_ready, wb_valid, wb_rd, flush,
    input  in_ready, out_valid, out_pc, out_opcode, out_func3, out_func7,
           out_rs1, out_rs2, out_rd, out_imm, out_rd_wen, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, wb_valid, wb_rd, flush,
    output in_ready, out_valid, out_pc, out_opcode, out_func3, out_func7,
           out_rs1, out_rs2, out_rd, out_imm, out_rd_wen, out_illegal
  );
endinterface

// File: rtl/idu_pipe.sv
// Instruction-decode stage with one output register and a per-register pending-write
// scoreboard. Define IDU_PERF_EN to add the perf_stall_cnt hazard-stall counter.
module idu_pipe #(
  parameter int XLEN    = 32,
  parameter int NR_REGS = 16,
  parameter int CNT_W   = 2
) (
  input  logic       clk,
  input  logic       rst,
  idu_pipe_if.slave  bus
`ifdef IDU_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int AW = $clog2(NR_REGS);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Counter update: one optional increment, up to two decrements, floor at zero.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c,
                                               input logic inc,
                                               input logic [1:0] dec);
    logic [CNT_W+1:0] sum;
    logic [CNT_W+1:0] sub;
    sum = {2'b00, c} + {{(CNT_W+1){1'b0}}, inc};
    sub = {{CNT_W{1'b0}}, dec};
    if (sum < sub) return '0;
    return CNT_W'(sum - sub);
  endfunction

  // ---- p0: combinational decode of the incoming instruction ----
  logic [31:0]              instr_p0;
  logic [6:0]               opc_p0;
  logic [2:0]               func3_p0;
  logic [AW-1:0]            rs1_p0, rs2_p0, rd_p0;
  logic                     known_p0, rs1_used_p0, rs2_used_p0, rd_writes_p0;
  logic                     rd_wen_p0, idx_bad_p0, illegal_p0;
  logic signed [31:0]       imm32_p0;
  logic signed [XLEN-1:0]   imm_p0;

  assign instr_p0 = bus.in_instr;
  assign opc_p0   = instr_p0[6:0];
  assign func3_p0 = instr_p0[14:12];
  assign rs1_p0   = instr_p0[15 +: AW];
  assign rs2_p0   = instr_p0[20 +: AW];
  assign rd_p0    = instr_p0[7 +: AW];

  always_comb begin
    known_p0     = 1'b1;
    rs1_used_p0  = 1'b1;
    rs2_used_p0  = 1'b0;
    rd_writes_p0 = 1'b0;
    imm32_p0     = '0;
    case (opc_p0)
      OP_IMM: begin
        rd_writes_p0 = 1'b1;
        if (func3_p0 == 3'b001 || func3_p0 == 3'b101)
          imm32_p0 = {27'd0, instr_p0[24:20]};
        else
          imm32_p0 = {{20{instr_p0[31]}}, instr_p0[31:20]};
      end
      OP_LOAD, OP_JALR: begin
        rd_writes_p0 = 1'b1;
        imm32_p0     = {{20{instr_p0[31]}}, instr_p0[31:20]};
      end
      OP_SYSTEM: begin
        rd_writes_p0 = (func3_p0 != 3'b000);
        imm32_p0     = {{20{instr_p0[31]}}, instr_p0[31:20]};
      end
      OP_STORE: begin
        rs2_used_p0 = 1'b1;
        imm32_p0    = {{20{instr_p0[31]}}, instr_p0[31:25], instr_p0[11:7]};
      end
      OP_BRANCH: begin
        rs2_used_p0 = 1'b1;
        imm32_p0    = {{19{instr_p0[31]}}, instr_p0[31], instr_p0[7],
                       instr_p0[30:25], instr_p0[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        rs1_used_p0  = 1'b0;
        rd_writes_p0 = 1'b1;
        imm32_p0     = {instr_p0[31:12], 12'd0};
      end
      OP_JAL: begin
        rs1_used_p0  = 1'b0;
        rd_writes_p0 = 1'b1;
        imm32_p0     = {{11{instr_p0[31]}}, instr_p0[31], instr_p0[19:12],
                        instr_p0[20], instr_p0[30:21], 1'b0};
      end
      OP_REG: begin
        rs2_used_p0  = 1'b1;
        rd_writes_p0 = 1'b1;
      end
      default: known_p0 = 1'b0;
    endcase
  end

  // In the 16-register build the top index bit of any used field must be clear.
  assign idx_bad_p0 = (NR_REGS == 16) &&
                      ((rs1_used_p0 && instr_p0[19]) ||
                       (rs2_used_p0 && instr_p0[24]) ||
                       (rd_writes_p0 && instr_p0[11]));
  assign illegal_p0 = !known_p0 || idx_bad_p0;
  assign rd_wen_p0  = rd_writes_p0 && (rd_p0 != '0);
  assign imm_p0     = XLEN'(imm32_p0);

  // ---- scoreboard and handshake ----
  logic [CNT_W-1:0] cnt     [NR_REGS];
  logic [CNT_W-1:0] cnt_nxt [NR_REGS];
  logic             hazard, accept, wb_dec, drop;

  logic                   vld_p1;
  logic [XLEN-1:0]        pc_p1;
  logic [6:0]             opc_p1;
  logic [2:0]             func3_p1;
  logic                   func7_p1;
  logic [AW-1:0]          rs1_p1, rs2_p1, rd_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic                   rd_wen_p1, illegal_p1;

  assign hazard = (rs1_used_p0 && (cnt[rs1_p0] != '0)) ||
                  (rs2_used_p0 && (cnt[rs2_p0] != '0)) ||
                  (rd_wen_p0 && (cnt[rd_p0] == CNT_MAX));

  assign bus.in_ready = rst && !bus.flush && !hazard && (!vld_p1 || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign wb_dec       = bus.wb_valid && (bus.wb_rd != '0);
  // A flushed entry that EXU never took gives back its pending write.
  assign drop         = bus.flush && vld_p1 && !bus.out_ready && rd_wen_p1;

  always_comb begin
    for (int r = 0; r < NR_REGS; r++) begin
      cnt_nxt[r] = sat_cnt(cnt[r],
                           accept && rd_wen_p0 && (rd_p0 == AW'(r)),
                           {1'b0, wb_dec && (bus.wb_rd == AW'(r))} +
                           {1'b0, drop && (rd_p1 == AW'(r))});
    end
  end

  // ---- p1: output register toward EXU ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '{default: '0};
      vld_p1     <= 1'b0;
      pc_p1      <= '0;
      opc_p1     <= '0;
      func3_p1   <= '0;
      func7_p1   <= 1'b0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      rd_p1      <= '0;
      imm_p1     <= '0;
      rd_wen_p1  <= 1'b0;
      illegal_p1 <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (bus.flush)          vld_p1 <= 1'b0;
      else if (accept)        vld_p1 <= 1'b1;
      else if (bus.out_ready) vld_p1 <= 1'b0;
      if (accept) begin
        pc_p1      <= bus.in_pc;
        opc_p1     <= opc_p0;
        func3_p1   <= func3_p0;
        func7_p1   <= instr_p0[30];
        rs1_p1     <= rs1_p0;
        rs2_p1     <= rs2_p0;
        rd_p1      <= rd_p0;
        imm_p1     <= imm_p0;
        rd_wen_p1  <= rd_wen_p0;
        illegal_p1 <= illegal_p0;
      end
    end
  end

  assign bus.out_valid   = vld_p1;
  assign bus.out_pc      = pc_p1;
  assign bus.out_opcode  = opc_p1;
  assign bus.out_func3   = func3_p1;
  assign bus.out_func7   = func7_p1;
  assign bus.out_rs1     = rs1_p1;
  assign bus.out_rs2     = rs2_p1;
  assign bus.out_rd      = rd_p1;
  assign bus.out_imm     = imm_p1;
  assign bus.out_rd_wen  = rd_wen_p1;
  assign bus.out_illegal = illegal_p1;

`ifdef IDU_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      perf_stall_cnt <= '0;
    else if (bus.in_valid && hazard && !bus.flush)
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: directed scenarios then random traffic, all checked each cycle
// against a spec-level decode/scoreboard model.
module tb_idu_pipe;
  localparam int XLEN    = 32;
  localparam int NR_REGS = 16;
  localparam int CNT_W   = 2;
  localparam int MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  idu_pipe_if #(.XLEN(XLEN), .NR_REGS(NR_REGS)) bus ();
`ifdef IDU_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  idu_pipe #(.XLEN(XLEN), .NR_REGS(NR_REGS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IDU_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct packed {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        wen;
    logic        ill;
    logic        u1;
    logic        u2;
  } dec_t;

  int          checks = 0;
  int          failures = 0;
  int          cnt_m [32];
  logic        mv;
  dec_t        md;
  logic [31:0] mpc;
  logic [31:0] perf_m;

  logic        s_in_ready, s_out_valid, s_ill;
  logic [31:0] s_imm, s_rd, s_perf;

  logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6f, 7'h33, 7'h00, 7'h7f};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference decode built from the opcode rules with plain integer arithmetic.
  function automatic dec_t ref_dec(input logic [31:0] i);
    dec_t   d;
    longint v;
    int     r1, r2, rdf;
    bit     known, wr;
    d     = '0;
    d.opc = i[6:0];
    d.f3  = i[14:12];
    d.f7  = i[30];
    r1    = int'(i[19:15]);
    r2    = int'(i[24:20]);
    rdf   = int'(i[11:7]);
    known = d.opc inside {7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33};
    d.u1  = !(d.opc inside {7'h37, 7'h17, 7'h6f});
    d.u2  = d.opc inside {7'h33, 7'h23, 7'h63};
    wr    = (d.opc inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h33, 7'h13, 7'h03}) ||
            (d.opc == 7'h73 && d.f3 != 3'd0);
    d.ill = !known || (NR_REGS == 16 &&
            ((d.u1 && r1 >= 16) || (d.u2 && r2 >= 16) || (wr && rdf >= 16)));
    d.rs1 = 5'(r1 % NR_REGS);
    d.rs2 = 5'(r2 % NR_REGS);
    d.rd  = 5'(rdf % NR_REGS);
    d.wen = wr && (d.rd != 5'd0);
    v = 0;
    case (d.opc)
      7'h13, 7'h03, 7'h67, 7'h73: begin
        if (d.opc == 7'h13 && (d.f3 == 3'd1 || d.f3 == 3'd5)) v = longint'(i[24:20]);
        else begin
          v = longint'(i[31:20]);
          if (v >= 2048) v -= 4096;
        end
      end
      7'h23: begin
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: v = -4096 * longint'(i[31]) + 2048 * longint'(i[7]) +
                 32 * longint'(i[30:25]) + 2 * longint'(i[11:8]);
      7'h37, 7'h17: v = longint'(i[31:12]) * 4096;
      7'h6f: v = -1048576 * longint'(i[31]) + 4096 * longint'(i[19:12]) +
                 2048 * longint'(i[20]) + 2 * longint'(i[30:21]);
      default: v = 0;
    endcase
    d.imm = 32'(v);
    return d;
  endfunction

  function automatic logic [31:0] enc_i(input int rd, input int rs1, input logic [11:0] imm);
    return {imm, 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction

  task automatic model_reset();
    foreach (cnt_m[r]) cnt_m[r] = 0;
    mv     = 1'b0;
    md     = '0;
    mpc    = '0;
    perf_m = '0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cyc();
    dec_t d;
    bit   hz, rdy, acc, drop;
    int   need;
    int   nc [32];
    @(negedge clk);
    d   = ref_dec(bus.in_instr);
    hz  = (d.u1 && cnt_m[d.rs1] != 0) || (d.u2 && cnt_m[d.rs2] != 0) ||
          (d.wen && cnt_m[d.rd] == MAX);
    rdy = rst && !bus.flush && !hz && (!mv || bus.out_ready);
    s_in_ready  = bus.in_ready;
    s_out_valid = bus.out_valid;
    s_imm       = bus.out_imm;
    s_rd        = 32'(bus.out_rd);
    s_ill       = bus.out_illegal;
    chk("in_ready", bus.in_ready, rdy);
    chk("out_valid", bus.out_valid, mv);
    chk("out_pc", bus.out_pc, mpc);
    chk("out_opcode", bus.out_opcode, md.opc);
    chk("out_func3", bus.out_func3, md.f3);
    chk("out_func7", bus.out_func7, md.f7);
    chk("out_rs1", bus.out_rs1, md.rs1);
    chk("out_rs2", bus.out_rs2, md.rs2);
    chk("out_rd", bus.out_rd, md.rd);
    chk("out_imm", bus.out_imm, md.imm);
    chk("out_rd_wen", bus.out_rd_wen, md.wen);
    chk("out_illegal", bus.out_illegal, md.ill);
`ifdef IDU_PERF_EN
    s_perf = perf_stall_cnt;
    chk("perf_stall_cnt", perf_stall_cnt, perf_m);
`else
    s_perf = '0;
`endif
    acc  = bus.in_valid && rdy;
    drop = bus.flush && mv && !bus.out_ready && md.wen;
    nc   = cnt_m;
    if (acc && d.wen) nc[d.rd]++;
    if (bus.wb_valid && bus.wb_rd != '0) begin
      need = 1 + ((drop && md.rd == 5'(bus.wb_rd)) ? 1 : 0);
      chk("wb_underflow", nc[bus.wb_rd] >= need, 1);
      if (nc[bus.wb_rd] > 0) nc[bus.wb_rd]--;
    end
    if (drop && nc[md.rd] > 0) nc[md.rd]--;
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      if (bus.in_valid && hz && !bus.flush) perf_m++;
      cnt_m = nc;
      if (bus.flush) mv = 1'b0;
      else if (acc) begin
        mv  = 1'b1;
        md  = d;
        mpc = bus.in_pc;
      end else if (bus.out_ready) mv = 1'b0;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = bus.in_pc + 32'd4;
    bus.out_ready = rdy;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      int r;
      r = 0;
      for (int j = 1; j < NR_REGS; j++) if (r == 0 && cnt_m[j] > 0) r = j;
      if (r == 0) break;
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 4'(r);
      cyc();
    end
    bus.wb_valid = 1'b0;
    bus.wb_rd    = '0;
  endtask

  initial begin
    logic [31:0] ins;
    int q [$];
    model_reset();
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = 32'h1000;
    bus.out_ready = 1'b1; bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.flush = 1'b0;

    // Reset: even with a valid instruction offered, nothing is accepted.
    bus.in_valid = 1'b1; bus.in_instr = enc_i(1, 0, 12'd5);
    cyc();
    cyc();
    chk("reset_in_ready", s_in_ready, 0);
    chk("reset_out_valid", s_out_valid, 0);
    rst = 1'b1;

    // Two independent immediates stream at full rate.
    drive(1, enc_i(1, 0, 12'd5), 1); cyc();
    chk("s1_ready", s_in_ready, 1);
    drive(1, enc_i(2, 0, 12'd7), 1); cyc();
    chk("s1_valid_a", s_out_valid, 1);
    chk("s1_imm_5", s_imm, 5);
    drive(0, 32'h0, 1); cyc();
    chk("s1_imm_7", s_imm, 7);

    // RAW stall released the cycle after the last writeback.
    drive(1, enc_r(3, 1, 2), 1); cyc();
    chk("s2_stall", s_in_ready, 0);
    bus.wb_valid = 1'b1; bus.wb_rd = 4'd1; cyc();
    chk("s2_stall_wb1", s_in_ready, 0);
    bus.wb_rd = 4'd2; cyc();
    chk("s2_stall_wb2", s_in_ready, 0);
    bus.wb_valid = 1'b0; bus.wb_rd = '0; cyc();
    chk("s2_accept", s_in_ready, 1);
    bus.in_valid = 1'b0; cyc();
    chk("s2_rd", s_rd, 3);

    // Backpressure holds the LUI result.
    drive(1, {20'h12345, 5'd5, 7'h37}, 1); cyc();
    drive(1, enc_i(8, 0, 12'd1), 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("s3_imm_hold", s_imm, 32'h1234_5000);
      chk("s3_no_accept", s_in_ready, 0);
    end
    bus.out_ready = 1'b1; cyc();
    chk("s3_release", s_in_ready, 1);
    bus.in_valid = 1'b0; cyc();

    // Out-of-range register in the 16-register build.
    drive(1, enc_r(17, 1, 2), 1); cyc();
    bus.in_valid = 1'b0; cyc();
    chk("s4_illegal", s_ill, 1);
    chk("s4_rd_trunc", s_rd, 1);

    // WAW counter saturation on x4.
    for (int k = 0; k < 3; k++) begin
      drive(1, enc_i(4, 0, 12'(k)), 1); cyc();
    end
    drive(1, enc_i(4, 0, 12'd9), 1); cyc();
    chk("s5_full", s_in_ready, 0);
    cyc(); cyc();
    bus.wb_valid = 1'b1; bus.wb_rd = 4'd4; cyc();
    chk("s5_full_wb", s_in_ready, 0);
    bus.wb_valid = 1'b0; bus.wb_rd = '0; cyc();
    chk("s5_accept", s_in_ready, 1);
    bus.in_valid = 1'b0; cyc();

    // Flush of an untaken x6 writer merged with a writeback to x6.
    drive(1, enc_i(6, 0, 12'd1), 1); cyc();
    drive(1, enc_i(6, 0, 12'd2), 1); cyc();
    drive(0, 32'h0, 0); cyc();
    bus.flush = 1'b1; bus.wb_valid = 1'b1; bus.wb_rd = 4'd6; cyc();
    chk("s6_flush_block", s_in_ready, 0);
    bus.flush = 1'b0; bus.wb_valid = 1'b0; bus.wb_rd = '0;
    drive(1, enc_i(7, 6, 12'd0), 1); cyc();
    chk("s6_flushed", s_out_valid, 0);
    chk("s6_x6_free", s_in_ready, 1);
`ifdef IDU_PERF_EN
    chk("perf_directed", s_perf, 7);
`endif
    bus.in_valid = 1'b0;
    drain();

    // Asynchronous reset while an instruction is held.
    drive(1, enc_i(9, 0, 12'd3), 0); cyc();
    bus.in_valid = 1'b0; cyc();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_ready", bus.in_ready, 0);
    model_reset();
    cyc();
    rst = 1'b1;
    drive(1, enc_r(10, 9, 9), 1); cyc();
    chk("async_rst_sb_clear", s_in_ready, 1);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 11)];
      ins[19:15] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ins[24:20] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ins[11:7]  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = ins;
      bus.in_pc     = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 19) == 0);
      q.delete();
      for (int r = 1; r < NR_REGS; r++)
        if (cnt_m[r] > ((bus.flush && mv && !bus.out_ready && md.wen && md.rd == 5'(r)) ? 1 : 0))
          q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 9) < 6) begin
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 4'(q[$urandom_range(0, q.size() - 1)]);
      end else begin
        bus.wb_valid = 1'($urandom_range(0, 1));
        bus.wb_rd    = '0;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/idu_pipe.md
# idu_pipe

Parametrised pipelined instruction-decode stage for the multi-cycle core, placed between the IFU and the EXU. It holds one decoded instruction in an output pipeline register and uses a valid/ready handshake on both sides. A per-register pending-write scoreboard stalls issue on RAW/WAW hazards against instructions still in flight, which allows more than one instruction to be outstanding. Register count is configurable (RV32E/RV32I), and the stage supports flush for redirect.

## Interface
- XLEN, 32: data/PC width.
- NR_REGS, 16: architectural register count; only 16 or 32 are legal.
- CNT_W, 2: width of each scoreboard counter; at most 2^CNT_W−1 in-flight writes per register.
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  IFU holds a valid instruction.
- in_ready  output  1  stage accepts this cycle.
- in_instr  input  32  raw instruction.
- in_pc  input  XLEN  instruction PC.
- out_valid  output  1  decoded instruction valid toward EXU.
- out_ready  input  1  EXU accepts.
- out_pc  output  XLEN  registered PC.
- out_opcode  output  7  instr[6:0].
- out_func3  output  3  instr[14:12].
- out_func7  output  1  instr[30].
- out_rs1, out_rs2, out_rd  output  AW  register indices, where AW = $clog2(NR_REGS).
- out_imm  output  XLEN  sign-extended immediate.
- out_rd_wen  output  1  instruction writes rd, and rd≠0.
- out_illegal  output  1  register index out of range, or unknown opcode.
- wb_valid  input  1  a writeback retires this cycle.
- wb_rd  input  AW  index of the retiring writeback.
- flush  input  1  discard the held instruction and block acceptance.
- perf_stall_cnt  output  32  hazard-stall cycles (exists only with the macro).

## Operation
- Decode is combinational on in_instr. The results are captured into the output register on accept, i.e. when in_valid && in_ready.
- Immediate by opcode:
  - I-type (0010011, 0000011, 1100111, 1110011): instr[31:20].
  - OP-IMM shifts: zero-extended instr[24:20].
  - S-type (0100011).
  - B-type (1100011).
  - U-type (0110111, 0010111).
  - J-type (1101111).
  - Any other opcode: imm = 0 and out_illegal = 1.
- Source usage:
  - rs1 is used by every opcode except 0110111, 0010111 and 1101111.
  - rs2 is used by 0110011, 0100011 and 1100011.
- rd write enable:
  - Set for 0110111, 0010111, 1101111, 1100111, 0110011, 0010011 and 0000011.
  - Set for 1110011 only when func3≠0 (ecall/mret do not write).
  - Forced to 0 when rd = 0.
- When NR_REGS = 16, any of instr[24], instr[19] or instr[11] set (on a used field) sets out_illegal. The index is then truncated to 4 bits.
- Scoreboard: one CNT_W counter per register, index 0 excluded.
  - hazard = (rs1 used && cnt[rs1]≠0) || (rs2 used && cnt[rs2]≠0) || (rd_wen && cnt[rd] at max).
  - in_ready = rst && !flush && !hazard && (!out_valid || out_ready).
  - On accept with rd_wen, cnt[rd] increments.
  - When wb_valid && wb_rd≠0, cnt[wb_rd] decrements.
  - If the same register is both incremented and decremented in one cycle, its count is unchanged.
  - A decrement at 0 is ignored, and the bench flags it as an error.
- Flush: out_valid clears next cycle. If the held entry was not taken that cycle and has rd_wen, cnt[out_rd] decrements; this merges with a wb decrement on the same index (net −2). Already-issued instructions are not un-counted.

## Timing
- Reset: out_valid = 0, every scoreboard counter = 0, all out_* data = 0, perf_stall_cnt = 0. in_ready = 0 while rst is low.
- Latency is 1 cycle, accept to out_valid.
- Full throughput (one instruction per cycle) when hazard-free and out_ready = 1.
- The output register holds stable while out_valid && !out_ready.
- A writeback in cycle N clears a hazard combinationally in cycle N+1, so the dependent instruction is accepted in N+1.
- Reset asserted mid-operation drops the held instruction and clears the scoreboard immediately.

## Configuration
- IDU_PERF_EN defined:
  - perf_stall_cnt exists.
  - It increments, wrapping at 2^32, each cycle where in_valid && hazard && !flush.
- IDU_PERF_EN undefined: the port and its counter are absent.

## Test plan
- Reset, then stream addi x1,x0,5 / addi x2,x0,7 with out_ready = 1 -> out_valid in cycles 1 and 2, out_imm = 5 then 7, cnt[1] = 1 and cnt[2] = 1.
- add x3,x1,x2 issued while cnt[1] = 1 -> in_ready = 0. Apply wb_valid with wb_rd = 1, then wb_rd = 2 -> accepted the cycle after the last writeback.
- out_ready = 0 for 3 cycles while holding lui x5,0x12345 -> out_imm = 0x12345000 stable, in_ready = 0, no new accept.
- NR_REGS = 16: add x17,x1,x2 -> out_illegal = 1, out_rd = 1.
- Three back-to-back writers to x4 with CNT_W = 2 and no writeback -> a 4th writer to x4 stalls until one wb_rd = 4.
- Flush while holding addi x6 (not taken) -> out_valid = 0 next cycle, cnt[6] returns to 0. With IDU_PERF_EN, perf_stall_cnt equals the number of stalled cycles from the earlier scenarios.
